// File: rtl/reg_file.sv
// reg_file: sixteen-entry, 48-bit (6 x 8-bit lane) vector register file for
// the decode stage. Two combinational read ports, one synchronous write port
// driven from writeback, and a 4-bit scalar tap of read port 2.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears every register
//   WE3   - write enable
//   A1    - read port 1 address
//   A2    - read port 2 address
//   A3    - write port address
//   WD3   - write data, lane 0 = [7:0] ... lane 5 = [47:40]
//   RD1   - contents of r[A1] (combinational)
//   RD2   - contents of r[A2] (combinational)
//   RD2I  - low nibble of lane 0 of r[A2] (combinational)
module reg_file (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            WE3,
    input  logic [3:0]      A1,
    input  logic [3:0]      A2,
    input  logic [3:0]      A3,
    input  logic [5:0][7:0] WD3,
    output logic [5:0][7:0] RD1,
    output logic [5:0][7:0] RD2,
    output logic [3:0]      RD2I
);

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LANES  = 6;
    localparam int unsigned LANE_W = 8;

    logic [LANES-1:0][LANE_W-1:0] regs [DEPTH];

    // Storage: whole-word writes, no lane enables; reset clears all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (WE3) begin
            regs[A3] <= WD3;
        end
    end

    // Reads come straight from storage; forwarding is left to the pipeline.
    assign RD1  = regs[A1];
    assign RD2  = regs[A2];
    assign RD2I = RD2[0][3:0];

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed bench for reg_file. A word-array model of the
// register contents is updated by the stimulus tasks from the architectural
// rules; a negedge compare process checks every read port against it, and
// literal expectations pin the model at key points.
module tb_reg_file;

    bit               clk = 1'b0;
    bit               clk_en = 1'b0;
    logic             rst_n;
    logic             we3;
    logic [3:0]       a1, a2, a3;
    logic [5:0][7:0]  wd3;
    logic [5:0][7:0]  rd1, rd2;
    logic [3:0]       rd2i;

    logic [47:0]      model [16];
    int               n_cmp = 0;
    int               n_err = 0;

    reg_file dut (
        .clk  (clk),
        .rst_n(rst_n),
        .WE3  (we3),
        .A1   (a1),
        .A2   (a2),
        .A3   (a3),
        .WD3  (wd3),
        .RD1  (rd1),
        .RD2  (rd2),
        .RD2I (rd2i)
    );

    // Gated clock so the reset sweep can run with no edges at all.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = 48'h0;
    endtask

    // Drive a write across one rising edge; it lands only if reset is released.
    task automatic wr(input logic [3:0] adr, input logic [47:0] d);
        we3 = 1'b1;
        a3  = adr;
        wd3 = d;
        @(posedge clk);
        if (rst_n === 1'b1) model[adr] = d;
        #1;
        we3 = 1'b0;
    endtask

    // Continuous check of both read ports against the model.
    always @(negedge clk) begin
        chk("cmp_rd1",  rd1, model[a1]);
        chk("cmp_rd2",  rd2, model[a2]);
        chk("cmp_rd2i", 48'(rd2i), 48'(model[a2][3:0]));
    end

    initial begin
        rst_n = 1'b0;
        we3   = 1'b0;
        a1    = '0;
        a2    = '0;
        a3    = '0;
        wd3   = '0;
        model_clear();

        // Reset sweep with the clock stopped.
        #1;
        for (int i = 0; i < 16; i++) begin
            a1 = 4'(i);
            a2 = 4'(15 - i);
            #1;
            chk("rst_rd1",  rd1, 48'h0);
            chk("rst_rd2",  rd2, 48'h0);
            chk("rst_rd2i", 48'(rd2i), 48'h0);
        end
        rst_n = 1'b1;
        #2;
        clk_en = 1'b1;
        @(negedge clk);
        #1;

        // Basic write then read.
        wr(4'd1, 48'h00000000ABCD);
        wr(4'd2, 48'h000000001234);
        a1 = 4'd1;
        a2 = 4'd2;
        #1;
        chk("basic_rd1",  rd1, 48'h00000000ABCD);
        chk("basic_rd2",  rd2, 48'h000000001234);
        chk("basic_rd2i", 48'(rd2i), 48'h4);

        // Disabled write leaves r1 alone.
        we3 = 1'b0;
        a3  = 4'd1;
        wd3 = 48'hFFFFFFFFFFFF;
        @(posedge clk);
        #1;
        chk("wdis_rd1", rd1, 48'h00000000ABCD);

        // Full-width data at the edge addresses.
        wr(4'd15, 48'h0123456789AB);
        wr(4'd0,  48'hFEDCBA987654);
        a1 = 4'd15;
        a2 = 4'd0;
        #1;
        chk("edge_rd1",  rd1, 48'h0123456789AB);
        chk("edge_rd2",  rd2, 48'hFEDCBA987654);
        chk("edge_rd2i", 48'(rd2i), 48'h4);
        a1 = 4'd0;
        a2 = 4'd15;
        #1;
        chk("swap_rd1",  rd1, 48'hFEDCBA987654);
        chk("swap_rd2",  rd2, 48'h0123456789AB);
        chk("swap_rd2i", 48'(rd2i), 48'hB);
        a1 = 4'd7;
        a2 = 4'd7;
        #1;
        chk("same_addr", rd1, rd2);

        // Read during write: old value before the edge, new value after.
        wr(4'd3, 48'h111111111111);
        a1  = 4'd3;
        we3 = 1'b1;
        a3  = 4'd3;
        wd3 = 48'h222222222222;
        @(negedge clk);
        #1;
        chk("rdw_before", rd1, 48'h111111111111);
        @(posedge clk);
        model[3] = 48'h222222222222;
        #1;
        we3 = 1'b0;
        chk("rdw_after", rd1, 48'h222222222222);

        // Asynchronous reset between edges clears everything immediately.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        a1 = 4'd1;
        a2 = 4'd15;
        #1;
        chk("mrst_rd1",  rd1, 48'h0);
        chk("mrst_rd2",  rd2, 48'h0);
        chk("mrst_rd2i", 48'(rd2i), 48'h0);

        // Write attempted under reset is lost.
        wr(4'd5, 48'hDEADBEEFCAFE);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        a1 = 4'd5;
        a2 = 4'd3;
        #1;
        chk("lost_wr_rd1", rd1, 48'h0);
        chk("lost_rd2",    rd2, 48'h0);

        // First write after release takes effect.
        wr(4'd5, 48'h0A0B0C0D0E0F);
        chk("post_rel_rd1", rd1, 48'h0A0B0C0D0E0F);
        a2 = 4'd5;
        #1;
        chk("post_rel_rd2i", 48'(rd2i), 48'hF);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
